// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen
// Brief  : Parametrised VGA raster timing generator with a pixel-tick divider
//          and a latency-matching delay line on sync/blank.
// Rev    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 1,
    parameter int CW       = 11
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Enable,
    output logic          PixelEn,
    output logic [CW-1:0] PixelX,
    output logic [CW-1:0] PixelY,
    output logic          Active,
    output logic          Hsync,
    output logic          Vsync,
    output logic          VGA_blank,
    output logic          LineStart,
    output logic          FrameStart,
    output logic [7:0]    FrameCount
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT        = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT        = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    // Idle stage contents: {hsync, vsync, blank}
    localparam logic [2:0]    PIPE_IDLE    = {~H_POL, ~V_POL, 1'b0};

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          pix_en_q, pix_en_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    logic          w_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_active;
    logic          w_h_s;
    logic          w_v_s;
    logic [2:0]    w_decode;
    logic [2:0]    w_pipe_out;

    always_comb begin
        div_d         = div_q;
        x_d           = x_q;
        y_d           = y_q;
        frame_cnt_d   = frame_cnt_q;
        w_tick        = 1'b0;
        w_h_wrap      = 1'b0;
        w_v_wrap      = 1'b0;

        if (Enable) begin
            w_tick = (div_q == DIV_LAST);
            div_d  = w_tick ? '0 : div_q + DW'(1);
        end

        w_h_wrap = w_tick && (x_q == H_LAST);
        w_v_wrap = w_h_wrap && (y_q == V_LAST);

        if (w_tick) begin
            x_d = w_h_wrap ? '0 : x_q + CW'(1);
            if (w_h_wrap) begin
                y_d = w_v_wrap ? '0 : y_q + CW'(1);
            end
            if (w_v_wrap) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end

        // Pulses are registered alongside the counter move they describe
        pix_en_d      = w_tick;
        line_start_d  = w_h_wrap;
        frame_start_d = w_v_wrap;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_cnt_q   <= '0;
            pix_en_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_cnt_q   <= frame_cnt_d;
            pix_en_q      <= pix_en_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign w_active = (x_q < H_ACT) && (y_q < V_ACT);
    assign w_h_s    = (x_q >= H_SYNC_FIRST) && (x_q <= H_SYNC_LAST);
    assign w_v_s    = (y_q >= V_SYNC_FIRST) && (y_q <= V_SYNC_LAST);
    assign w_decode = {(w_h_s ? H_POL : ~H_POL), (w_v_s ? V_POL : ~V_POL), w_active};

    generate
        if (PIPE_DLY == 0) begin : g_no_pipe
            assign w_pipe_out = w_decode;
        end else begin : g_pipe
            logic [3*PIPE_DLY-1:0] pipe_q, pipe_d;
            logic [3*PIPE_DLY+2:0] w_chain;

            // Stage 0 sits in the low bits; the oldest stage drives the pins
            assign w_chain    = {pipe_q, w_decode};
            assign w_pipe_out = w_chain[3*PIPE_DLY+2 -: 3];

            always_comb begin
                pipe_d = pipe_q;
                if (w_tick) begin
                    pipe_d = w_chain[3*PIPE_DLY-1:0];
                end
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    pipe_q <= {PIPE_DLY{PIPE_IDLE}};
                end else begin
                    pipe_q <= pipe_d;
                end
            end
        end
    endgenerate

    assign PixelEn    = pix_en_q;
    assign PixelX     = x_q;
    assign PixelY     = y_q;
    assign Active     = w_active;
    assign Hsync      = w_pipe_out[2];
    assign Vsync      = w_pipe_out[1];
    assign VGA_blank  = w_pipe_out[0];
    assign LineStart  = line_start_q;
    assign FrameStart = frame_start_q;
    assign FrameCount = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Directed self-checking bench for vga_timing_gen (three configs).
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instance A: all defaults
    logic        a_rst, a_en, a_pix_en, a_act, a_hs, a_vs, a_blank, a_ls, a_fs;
    logic [10:0] a_x, a_y;
    logic [7:0]  a_fc;
    // Instance B: 800-pixel lines, short frame, CLK_DIV=1, PIPE_DLY=3, active-high syncs
    logic        b_rst, b_en, b_pix_en, b_act, b_hs, b_vs, b_blank, b_ls, b_fs;
    logic [10:0] b_x, b_y;
    logic [7:0]  b_fc;
    // Instance C: tiny raster, CLK_DIV=1, PIPE_DLY=0, CW=4
    logic        c_rst, c_en, c_pix_en, c_act, c_hs, c_vs, c_blank, c_ls, c_fs;
    logic [3:0]  c_x, c_y;
    logic [7:0]  c_fc;

    vga_timing_gen u_a (
        .Clk(Clk), .Reset(a_rst), .Enable(a_en), .PixelEn(a_pix_en),
        .PixelX(a_x), .PixelY(a_y), .Active(a_act), .Hsync(a_hs), .Vsync(a_vs),
        .VGA_blank(a_blank), .LineStart(a_ls), .FrameStart(a_fs), .FrameCount(a_fc)
    );

    vga_timing_gen #(
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .PIPE_DLY(3), .CW(11)
    ) u_b (
        .Clk(Clk), .Reset(b_rst), .Enable(b_en), .PixelEn(b_pix_en),
        .PixelX(b_x), .PixelY(b_y), .Active(b_act), .Hsync(b_hs), .Vsync(b_vs),
        .VGA_blank(b_blank), .LineStart(b_ls), .FrameStart(b_fs), .FrameCount(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .PIPE_DLY(0), .CW(4)
    ) u_c (
        .Clk(Clk), .Reset(c_rst), .Enable(c_en), .PixelEn(c_pix_en),
        .PixelX(c_x), .PixelY(c_y), .Active(c_act), .Hsync(c_hs), .Vsync(c_vs),
        .VGA_blank(c_blank), .LineStart(c_ls), .FrameStart(c_fs), .FrameCount(c_fc)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int k, n, cnt_hs, cnt_bl, cnt_vs, cnt_act, cnt_act_v, cnt_ls, bad;
    int first_x, first_y, first_pe, fs_last, fs_cnt, fc255, fc0;
    logic rec_hs, rec_vs, rec_bl;

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_en  = 1'b1; b_en  = 1'b1; c_en  = 1'b1;
        repeat (3) @(negedge Clk);

        // ---------------- A: reset state ----------------
        chk("a_rst_pixen", a_pix_en, 0);
        chk("a_rst_x", a_x, 0);
        chk("a_rst_y", a_y, 0);
        chk("a_rst_hsync", a_hs, 1);
        chk("a_rst_vsync", a_vs, 1);
        chk("a_rst_blank", a_blank, 0);
        chk("a_rst_fc", a_fc, 0);
        chk("a_rst_pulses", {a_ls, a_fs}, 0);
        chk("a_rst_active", a_act, 1);

        a_rst = 1'b0;
        @(negedge Clk);
        chk("a_c1_pixen", a_pix_en, 0);
        chk("a_c1_x", a_x, 0);
        @(negedge Clk);
        chk("a_c2_pixen", a_pix_en, 1);
        chk("a_c2_x", a_x, 1);
        @(negedge Clk);
        chk("a_c3_pixen", a_pix_en, 0);
        @(negedge Clk);
        chk("a_c4_pixen", a_pix_en, 1);
        chk("a_c4_x", a_x, 2);

        // First LineStart lands 1600 Clk after reset release
        k = 4;
        do begin @(negedge Clk); k++; end while (!a_ls && k < 2000);
        chk("a_first_ls_clk", k, 1600);
        chk("a_first_ls_x", a_x, 0);
        chk("a_first_ls_y", a_y, 1);
        chk("a_first_ls_fs", a_fs, 0);

        // One full visible line
        cnt_hs = 0; cnt_bl = 0; cnt_vs = 0; cnt_ls = 0; first_x = -1;
        for (int i = 1; i <= 1600; i++) begin
            @(negedge Clk);
            if (!a_hs) begin
                cnt_hs++;
                if (first_x < 0) first_x = a_x;
            end
            if (a_blank) cnt_bl++;
            if (!a_vs) cnt_vs++;
            if (a_ls && i < 1600) cnt_ls++;
        end
        chk("a_line_ls_period", a_ls, 1);
        chk("a_line_ls_extra", cnt_ls, 0);
        chk("a_line_hs_low_clk", cnt_hs, 192);
        chk("a_line_hs_first_x", first_x, 657);
        chk("a_line_blank_clk", cnt_bl, 1280);
        chk("a_line_vs_low", cnt_vs, 0);

        // Freeze at X=300 with the divider one cycle short of a tick
        n = 0;
        do begin @(negedge Clk); n++; end while (!(a_x == 300 && a_pix_en) && n < 2000);
        chk("a_reach_x300", a_x, 300);
        @(negedge Clk);
        a_en   = 1'b0;
        rec_hs = a_hs; rec_vs = a_vs; rec_bl = a_blank;
        chk("a_frz_blank", rec_bl, 1);
        bad = 0;
        repeat (37) begin
            @(negedge Clk);
            if (a_x != 300 || a_y != 2 || a_pix_en || a_ls || a_fs ||
                a_hs != rec_hs || a_vs != rec_vs || a_blank != rec_bl) bad++;
        end
        chk("a_frz_hold", bad, 0);
        a_en = 1'b1;
        @(negedge Clk);
        chk("a_resume_pixen", a_pix_en, 1);
        chk("a_resume_x", a_x, 301);
        @(negedge Clk);
        chk("a_resume_gap", a_pix_en, 0);
        a_rst = 1'b1;

        // ---------------- B: full frame ----------------
        chk("b_rst_hsync", b_hs, 0);
        chk("b_rst_vsync", b_vs, 0);
        chk("b_rst_blank", b_blank, 0);
        b_rst = 1'b0;
        k = 0; cnt_vs = 0; cnt_act = 0; cnt_act_v = 0; cnt_bl = 0;
        first_x = -1; first_y = -1; first_pe = -1;
        do begin
            @(negedge Clk); k++;
            if (k == 1) begin
                first_pe = b_pix_en;
                chk("b_c1_x", b_x, 1);
            end
            if (b_vs) begin
                cnt_vs++;
                if (first_x < 0) begin first_x = b_x; first_y = b_y; end
            end
            if (b_act) cnt_act++;
            if (b_act && b_y >= 8) cnt_act_v++;
            if (b_blank) cnt_bl++;
        end while (!b_fs && k < 13000);
        chk("b_c1_pixen", first_pe, 1);
        chk("b_fs_period", k, 12000);
        chk("b_fs_implies_ls", b_ls, 1);
        chk("b_fc_after_frame", b_fc, 1);
        chk("b_vs_high_clk", cnt_vs, 1600);
        chk("b_vs_first_x", first_x, 3);
        chk("b_vs_first_y", first_y, 10);
        chk("b_active_clk", cnt_act, 5120);
        chk("b_active_vblank", cnt_act_v, 0);
        chk("b_blank_clk", cnt_bl, 5120);

        // Reset deep inside vertical sync
        n = 0;
        do begin @(negedge Clk); n++; end while (!(b_x == 700 && b_y == 11) && n < 13000);
        chk("b_pre_rst_vsync", b_vs, 1);
        chk("b_pre_rst_fc", b_fc, 1);
        b_rst = 1'b1;
        @(negedge Clk);
        chk("b_rst_x", b_x, 0);
        chk("b_rst_y", b_y, 0);
        chk("b_rst2_hsync", b_hs, 0);
        chk("b_rst2_vsync", b_vs, 0);
        chk("b_rst2_blank", b_blank, 0);
        chk("b_rst_fc", b_fc, 0);
        chk("b_rst_pulses", {b_pix_en, b_ls, b_fs}, 0);

        // ---------------- C: tiny raster, FrameCount wrap ----------------
        c_rst = 1'b0;
        k = 0; bad = 0; fs_cnt = 0; fs_last = 0; fc255 = -1; fc0 = -1; first_x = -1;
        do begin
            @(negedge Clk); k++;
            if ((c_hs == 1'b0) != (c_x == 4'd5)) bad++;
            if ((c_vs == 1'b0) != (c_y == 4'd3)) bad++;
            if (c_blank != (c_x < 4'd4 && c_y < 4'd2)) bad++;
            if (c_act != c_blank) bad++;
            if (c_fs && !c_ls) bad++;
            if (c_fs) begin
                fs_cnt++;
                if (k - fs_last != 35) bad++;
                fs_last = k;
                if (fs_cnt == 1) first_x = c_fc;
                if (fs_cnt == 255) fc255 = c_fc;
                if (fs_cnt == 256) fc0 = c_fc;
            end
        end while (fs_cnt < 256 && k < 10000);
        chk("c_frames_seen", fs_cnt, 256);
        chk("c_decode_errs", bad, 0);
        chk("c_fc_first", first_x, 1);
        chk("c_fc_255", fc255, 255);
        chk("c_fc_wrap", fc0, 0);
        chk("c_end_xy", {c_x, c_y}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
